// File: rtl/reg_file_sb.sv
// reg_file_sb: two combinational read ports, one write port, register 0 hardwired to zero,
// and a per-register busy scoreboard. Optional write-to-read bypass when REG_FILE_BYPASS_EN is defined.
module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Read_addr_A,
  input  logic [ADDR_W-1:0] Read_addr_B,
  output logic [DATA_W-1:0] RDA,
  output logic [DATA_W-1:0] RDB,
  output logic              busy_A,
  output logic              busy_B,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              WE,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] WD,
  output logic [ADDR_W:0]   pending_cnt
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_r [NREG];
  logic [NREG-1:0]   busy_r;
  logic [NREG-1:0]   busy_next_s;
  logic [ADDR_W:0]   cnt_r;
  logic              wr_en_s;
  logic              iss_en_s;
  logic              inc_s;
  logic              dec_s;
  logic              byp_a_s;
  logic              byp_b_s;
  logic [DATA_W-1:0] byp_data_s;

  assign wr_en_s  = WE && (write_addr != ZERO_ADDR);
  assign iss_en_s = issue && (issue_addr != ZERO_ADDR);

  // The count moves only when a bit actually flips; issue to a busy register and a
  // write-back that is overridden by a same-register issue both leave it alone.
  assign inc_s = iss_en_s && !busy_r[issue_addr];
  assign dec_s = wr_en_s && busy_r[write_addr] && !(iss_en_s && (issue_addr == write_addr));

`ifdef REG_FILE_BYPASS_EN
  assign byp_a_s    = wr_en_s && (write_addr == Read_addr_A);
  assign byp_b_s    = wr_en_s && (write_addr == Read_addr_B);
  assign byp_data_s = WD;
`else
  assign byp_a_s    = 1'b0;
  assign byp_b_s    = 1'b0;
  assign byp_data_s = {DATA_W{1'b0}};
`endif

  // Scoreboard next state: issue sets, else write-back clears, else hold.
  always_comb begin
    busy_next_s = {NREG{1'b0}};
    for (int r = 0; r < NREG; r++) begin
      if (r == 0) begin
        busy_next_s[r] = 1'b0;
      end else if (iss_en_s && (issue_addr == ADDR_W'(r))) begin
        busy_next_s[r] = 1'b1;
      end else if (wr_en_s && (write_addr == ADDR_W'(r))) begin
        busy_next_s[r] = 1'b0;
      end else begin
        busy_next_s[r] = busy_r[r];
      end
    end
  end

  // Register array, busy bits and pending count with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
      busy_r <= {NREG{1'b0}};
      cnt_r  <= {(ADDR_W+1){1'b0}};
    end else begin
      if (wr_en_s) begin
        mem_r[write_addr] <= WD;
      end
      busy_r <= busy_next_s;
      if (inc_s && !dec_s) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else if (dec_s && !inc_s) begin
        cnt_r <= cnt_r - CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Read ports: bypass first, then the hardwired zero register, then stored state.
  always_comb begin
    RDA    = {DATA_W{1'b0}};
    RDB    = {DATA_W{1'b0}};
    busy_A = 1'b0;
    busy_B = 1'b0;
    if (byp_a_s) begin
      RDA    = byp_data_s;
      busy_A = 1'b0;
    end else if (Read_addr_A == ZERO_ADDR) begin
      RDA    = {DATA_W{1'b0}};
      busy_A = 1'b0;
    end else begin
      RDA    = mem_r[Read_addr_A];
      busy_A = busy_r[Read_addr_A];
    end
    if (byp_b_s) begin
      RDB    = byp_data_s;
      busy_B = 1'b0;
    end else if (Read_addr_B == ZERO_ADDR) begin
      RDB    = {DATA_W{1'b0}};
      busy_B = 1'b0;
    end else begin
      RDB    = mem_r[Read_addr_B];
      busy_B = busy_r[Read_addr_B];
    end
  end

  assign pending_cnt = cnt_r;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios, randomized traffic against an
// array/popcount reference model, asynchronous reset, and a 16x8 instance for the depth boundary.
module tb_reg_file_sb;

  logic        clk;
  logic        rst;
  logic [4:0]  read_addr_a, read_addr_b, issue_addr, write_addr;
  logic [31:0] rda, rdb, wd;
  logic        busy_a, busy_b, issue, we;
  logic [5:0]  pending_cnt;

  logic        s_rst;
  logic [2:0]  s_ra, s_rb, s_ia, s_wa;
  logic [15:0] s_rda, s_rdb, s_wd;
  logic        s_busy_a, s_busy_b, s_issue, s_we;
  logic [3:0]  s_cnt;

  logic [31:0] m_mem [32];
  bit          m_busy [32];

  int unsigned n_vec;
  int unsigned n_err;

  reg_file_sb u_dut (
    .clk(clk), .rst(rst),
    .Read_addr_A(read_addr_a), .Read_addr_B(read_addr_b),
    .RDA(rda), .RDB(rdb), .busy_A(busy_a), .busy_B(busy_b),
    .issue(issue), .issue_addr(issue_addr),
    .WE(we), .write_addr(write_addr), .WD(wd),
    .pending_cnt(pending_cnt)
  );

  reg_file_sb #(.DATA_W(16), .ADDR_W(3)) u_dut_small (
    .clk(clk), .rst(s_rst),
    .Read_addr_A(s_ra), .Read_addr_B(s_rb),
    .RDA(s_rda), .RDB(s_rdb), .busy_A(s_busy_a), .busy_B(s_busy_b),
    .issue(s_issue), .issue_addr(s_ia),
    .WE(s_we), .write_addr(s_wa), .WD(s_wd),
    .pending_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = 32'd0;
      m_busy[i] = 1'b0;
    end
  endfunction

  // Edge behaviour straight from the rules: data write, then clear, then set (set wins).
  function automatic void model_edge();
    if (we && write_addr != 5'd0) begin
      m_mem[write_addr]  = wd;
      m_busy[write_addr] = 1'b0;
    end
    if (issue && issue_addr != 5'd0) m_busy[issue_addr] = 1'b1;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    logic [31:0] v;
    v = (ra == 5'd0) ? 32'd0 : m_mem[ra];
`ifdef REG_FILE_BYPASS_EN
    if (we && write_addr != 5'd0 && write_addr == ra) v = wd;
`endif
    return v;
  endfunction

  function automatic logic [31:0] exp_busy(input logic [4:0] ra);
    logic [31:0] v;
    v = (ra == 5'd0) ? 32'd0 : 32'(m_busy[ra]);
`ifdef REG_FILE_BYPASS_EN
    if (we && write_addr != 5'd0 && write_addr == ra) v = 32'd0;
`endif
    return v;
  endfunction

  function automatic logic [31:0] exp_cnt();
    int n;
    n = 0;
    for (int i = 1; i < 32; i++) n += int'(m_busy[i]);
    return 32'(n);
  endfunction

  task automatic drive(input bit iss, input int ia, input bit we_i, input int wa_i, input logic [31:0] wd_i);
    issue      = iss;
    issue_addr = 5'(ia);
    we         = we_i;
    write_addr = 5'(wa_i);
    wd         = wd_i;
  endtask

  // Called just after a falling edge with inputs applied; checks, takes the edge, returns at next falling edge.
  task automatic tick();
    #1;
    chk("rda", rda, exp_rd(read_addr_a));
    chk("rdb", rdb, exp_rd(read_addr_b));
    chk("busy_a", 32'(busy_a), exp_busy(read_addr_a));
    chk("busy_b", 32'(busy_b), exp_busy(read_addr_b));
    chk("pending_cnt", 32'(pending_cnt), exp_cnt());
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
  endtask

  task automatic tick_small();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    s_rst = 1'b1;
    drive(1'b0, 0, 1'b0, 0, 32'd0);
    read_addr_a = 5'd5;
    read_addr_b = 5'd9;
    s_issue = 1'b0; s_ia = 3'd0; s_we = 1'b0; s_wa = 3'd0; s_wd = 16'd0;
    s_ra = 3'd0; s_rb = 3'd0;
    model_reset();
    #1;
    rst = 1'b0;
    s_rst = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_rda", rda, 32'd0);
    chk("reset_rdb", rdb, 32'd0);
    chk("reset_busy_a", 32'(busy_a), 32'd0);
    chk("reset_cnt", 32'(pending_cnt), 32'd0);
    rst = 1'b1;
    s_rst = 1'b1;
    @(negedge clk);

    // Zero register: write and issue to address 0 have no effect.
    drive(1'b0, 0, 1'b1, 0, 32'hDEADBEEF);
    tick();
    drive(1'b1, 0, 1'b0, 0, 32'd0);
    tick();
    drive(1'b0, 0, 1'b0, 0, 32'd0);
    read_addr_a = 5'd0;
    #1;
    chk("zero_rda", rda, 32'd0);
    chk("zero_busy", 32'(busy_a), 32'd0);
    chk("zero_cnt", 32'(pending_cnt), 32'd0);
    tick();

    // Scoreboard: issue r5 then r9, write back r5.
    drive(1'b1, 5, 1'b0, 0, 32'd0);
    tick();
    drive(1'b1, 9, 1'b0, 0, 32'd0);
    tick();
    drive(1'b0, 0, 1'b0, 0, 32'd0);
    read_addr_a = 5'd5;
    #1;
    chk("sb_cnt2", 32'(pending_cnt), 32'd2);
    chk("sb_busy5", 32'(busy_a), 32'd1);
    drive(1'b0, 0, 1'b1, 5, 32'h1234);
    tick();
    drive(1'b0, 0, 1'b0, 0, 32'd0);
    #1;
    chk("sb_busy5_clr", 32'(busy_a), 32'd0);
    chk("sb_cnt1", 32'(pending_cnt), 32'd1);
    chk("sb_rd5", rda, 32'h1234);
    tick();

    // Collision: r7 busy, issue and write back r7 together.
    drive(1'b1, 7, 1'b0, 0, 32'd0);
    tick();
    drive(1'b1, 7, 1'b1, 7, 32'hA5A5);
    tick();
    drive(1'b0, 0, 1'b0, 0, 32'd0);
    read_addr_a = 5'd7;
    #1;
    chk("col_busy7", 32'(busy_a), 32'd1);
    chk("col_cnt", 32'(pending_cnt), 32'd2);
    chk("col_rd7", rda, 32'hA5A5);
    tick();

    // Bypass: r3 busy and never written, then write back r3 while reading it.
    drive(1'b1, 3, 1'b0, 0, 32'd0);
    tick();
    drive(1'b0, 0, 1'b1, 3, 32'hCAFE);
    read_addr_a = 5'd3;
    #1;
`ifdef REG_FILE_BYPASS_EN
    chk("byp_rda", rda, 32'hCAFE);
    chk("byp_busy", 32'(busy_a), 32'd0);
`else
    chk("nobyp_rda", rda, 32'd0);
    chk("nobyp_busy", 32'(busy_a), 32'd1);
`endif
    tick();
    drive(1'b0, 0, 1'b0, 0, 32'd0);
    #1;
    chk("byp_next_rda", rda, 32'hCAFE);
    tick();

    // Randomized traffic with deliberate address overlaps.
    for (int k = 0; k < 3000; k++) begin
      int ia, wa;
      ia = $urandom_range(0, 31);
      wa = ($urandom_range(0, 3) == 0) ? ia : $urandom_range(0, 31);
      drive(1'($urandom_range(0, 1)), ia, 1'($urandom_range(0, 1)), wa, $urandom);
      read_addr_a = ($urandom_range(0, 3) == 0) ? 5'(wa) : 5'($urandom_range(0, 31));
      read_addr_b = ($urandom_range(0, 3) == 0) ? 5'(wa) : 5'($urandom_range(0, 31));
      tick();
    end

    // Asynchronous reset mid-cycle after filling every register.
    for (int r = 1; r < 32; r++) begin
      drive(1'b0, 0, 1'b1, r, $urandom | 32'h1);
      tick();
    end
    drive(1'b1, 1, 1'b0, 0, 32'd0);
    tick();
    drive(1'b0, 0, 1'b0, 0, 32'd0);
    read_addr_a = 5'd1;
    read_addr_b = 5'd31;
    #1;
    chk("pre_rst_busy1", 32'(busy_a), 32'd1);
    chk("pre_rst_rda", rda, m_mem[1]);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_rda", rda, 32'd0);
    chk("rst_rdb", rdb, 32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_cnt", 32'(pending_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    drive(1'b1, 4, 1'b1, 4, 32'h77);
    tick();
    rst = 1'b1;
    drive(1'b0, 0, 1'b0, 0, 32'd0);
    read_addr_a = 5'd4;
    #1;
    chk("rst_ignored_rd4", rda, 32'd0);
    chk("rst_ignored_busy4", 32'(busy_a), 32'd0);
    tick();

    // Small configuration: 7 usable registers.
    s_issue = 1'b1; s_ia = 3'd5;
    tick_small();
    s_ia = 3'd3;
    tick_small();
    s_issue = 1'b0;
    s_ra = 3'd5;
    #1;
    chk("small_cnt2", 32'(s_cnt), 32'd2);
    chk("small_busy5", 32'(s_busy_a), 32'd1);
    s_we = 1'b1; s_wa = 3'd5; s_wd = 16'h1234;
    tick_small();
    s_we = 1'b0;
    #1;
    chk("small_busy5_clr", 32'(s_busy_a), 32'd0);
    chk("small_cnt1", 32'(s_cnt), 32'd1);
    chk("small_rd5", 32'(s_rda), 32'h1234);
    for (int r = 1; r < 8; r++) begin
      s_issue = 1'b1;
      s_ia = 3'(r);
      tick_small();
    end
    s_issue = 1'b0;
    s_ra = 3'd7;
    #1;
    chk("small_cnt7", 32'(s_cnt), 32'd7);
    chk("small_busy7", 32'(s_busy_a), 32'd1);
    for (int r = 1; r < 8; r++) begin
      s_we = 1'b1;
      s_wa = 3'(r);
      s_wd = 16'(r);
      tick_small();
    end
    s_we = 1'b0;
    #1;
    chk("small_cnt0", 32'(s_cnt), 32'd0);
    chk("small_rd7", 32'(s_rda), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
